// File: rtl/core_fetch_seq_if.sv
// ============================================================================
// Module   : core_fetch_seq_if
// Brief    : ITCM read port, redirect and decode handshake of the fetch sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface core_fetch_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] inst_addr_o;
    logic [DATA_W-1:0] inst_data_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [DATA_W-1:0] id_inst_o;
    logic [ADDR_W-1:0] id_pc_o;

    modport master (
        output inst_addr_o,
        input  inst_data_i,
        input  redirect_i,
        input  redirect_pc_i,
        output id_valid_o,
        input  id_ready_i,
        output id_inst_o,
        output id_pc_o
    );

    modport slave (
        input  inst_addr_o,
        output inst_data_i,
        output redirect_i,
        output redirect_pc_i,
        input  id_valid_o,
        output id_ready_i,
        input  id_inst_o,
        input  id_pc_o
    );
endinterface

`default_nettype wire

// File: rtl/core_fetch_seq.sv
// ============================================================================
// Module   : core_fetch_seq
// Brief    : Instruction-fetch sequencer with 2-entry {pc, inst} FIFO and
//            redirect flush. Optional FETCH_PERF_EN adds pop/redirect counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_fetch_seq #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    core_fetch_seq_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      fetch_cnt_o,
    output logic [31:0]      flush_cnt_o
`endif
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_req;
    logic [ADDR_W-1:0] r_req_pc;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_e0_pc;
    logic [DATA_W-1:0] r_e0_inst;
    logic [ADDR_W-1:0] r_e1_pc;
    logic [DATA_W-1:0] r_e1_inst;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic              w_slot1;
    logic [ADDR_W-1:0] w_target;
    logic              w_unused_lsb;

    assign w_pop    = (r_count != 2'd0) & bus.id_ready_i;
    assign w_push   = r_req & ~bus.redirect_i;
    // Occupancy after this cycle's pop, counting the response still in flight.
    assign w_occ    = {1'b0, r_count} + {2'b00, r_req} - {2'b00, w_pop};
    assign w_issue  = ~bus.redirect_i & (w_occ <= 3'd1);
    assign w_slot1  = (r_count - {1'b0, w_pop}) == 2'd1;
    assign w_target = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign w_unused_lsb = ^bus.redirect_pc_i[1:0];

    assign bus.inst_addr_o = r_pc;
    assign bus.id_valid_o  = r_count != 2'd0;
    assign bus.id_inst_o   = r_e0_inst;
    assign bus.id_pc_o     = r_e0_pc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc      <= RESET_PC;
            r_req     <= 1'b0;
            r_req_pc  <= '0;
            r_count   <= 2'd0;
            r_e0_pc   <= '0;
            r_e0_inst <= '0;
            r_e1_pc   <= '0;
            r_e1_inst <= '0;
        end else begin
            r_req    <= w_issue;
            r_req_pc <= r_pc;
            if (bus.redirect_i) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(4);
            end

            if (bus.redirect_i) begin
                r_count <= 2'd0;
            end else begin
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
                if (w_pop) begin
                    r_e0_pc   <= r_e1_pc;
                    r_e0_inst <= r_e1_inst;
                end
                // Later assignments override the shift when the push lands in the head slot.
                if (w_push && !w_slot1) begin
                    r_e0_pc   <= r_req_pc;
                    r_e0_inst <= bus.inst_data_i;
                end
                if (w_push && w_slot1) begin
                    r_e1_pc   <= r_req_pc;
                    r_e1_inst <= bus.inst_data_i;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_pop) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (bus.redirect_i) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_fetch_seq.sv
// ============================================================================
// Module   : tb_core_fetch_seq
// Brief    : Directed bench for core_fetch_seq with a pc scoreboard on pops.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_core_fetch_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_fetch_seq_if itf ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    core_fetch_seq dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (itf)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o (fetch_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          n_pops = 0;
    int          n_redir = 0;
    int          n;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 60) begin
            step();
            cyc++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ITCM model: word[i] = i, one-cycle read latency.
    always @(posedge clk) itf.inst_data_i <= itf.inst_addr_o >> 2;

    always @(negedge clk) begin
        if (!rst && itf.id_valid_o && itf.id_ready_i) begin
            logic [31:0] e;
            n_pops++;
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("id_pc", itf.id_pc_o, e);
                check("id_inst", itf.id_inst_o, e >> 2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        itf.id_ready_i    = 1'b0;
        itf.redirect_i    = 1'b0;
        itf.redirect_pc_i = 32'h0;
        repeat (3) step();
        check("rst_valid", {31'b0, itf.id_valid_o}, 32'd0);
        check("rst_id_pc", itf.id_pc_o, 32'h0);
        check("rst_id_inst", itf.id_inst_o, 32'h0);
        check("rst_addr", itf.inst_addr_o, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_fetch_cnt", fetch_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
`endif

        // Reset release with ready high: valid two cycles later, then streaming.
        rst = 1'b0;
        itf.id_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        step();
        check("lat_r1_valid", {31'b0, itf.id_valid_o}, 32'd0);
        check("lat_r1_addr", itf.inst_addr_o, 32'h4);
        step();
        check("lat_r2_valid", {31'b0, itf.id_valid_o}, 32'd1);
        check("lat_r2_pc", itf.id_pc_o, 32'h0);
        drain(n);
        check("thru_stream", 32'(n), 32'd8);
        itf.id_ready_i = 1'b0;

        // Backpressure: FIFO fills, head and address hold.
        repeat (5) step();
        check("bp_valid", {31'b0, itf.id_valid_o}, 32'd1);
        check("bp_pc", itf.id_pc_o, 32'h20);
        check("bp_addr", itf.inst_addr_o, 32'h28);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h20 + 32'(i * 4));
        itf.id_ready_i = 1'b1;
        drain(n);
        check("thru_resume", 32'(n), 32'd4);
        itf.id_ready_i = 1'b0;
        repeat (3) step();

        // Redirect to 0x100 with stale entries buffered.
        itf.redirect_i    = 1'b1;
        itf.redirect_pc_i = 32'h100;
        n_redir++;
        step();
        itf.redirect_i = 1'b0;
        check("rd_t1_valid", {31'b0, itf.id_valid_o}, 32'd0);
        check("rd_t1_addr", itf.inst_addr_o, 32'h100);
        step();
        check("rd_t2_valid", {31'b0, itf.id_valid_o}, 32'd0);
        step();
        check("rd_t3_valid", {31'b0, itf.id_valid_o}, 32'd1);
        check("rd_t3_pc", itf.id_pc_o, 32'h100);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        itf.id_ready_i = 1'b1;
        drain(n);
        check("thru_redirect", 32'(n), 32'd3);
        itf.id_ready_i = 1'b0;
        repeat (3) step();

        // Misaligned redirect coinciding with a pop of the head entry.
        exp_q.push_back(32'h10C);
        itf.id_ready_i    = 1'b1;
        itf.redirect_i    = 1'b1;
        itf.redirect_pc_i = 32'h203;
        n_redir++;
        step();
        itf.redirect_i = 1'b0;
        check("rdpop_addr", itf.inst_addr_o, 32'h200);
        check("rdpop_consumed", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        drain(n);
        check("rdpop_lat", 32'(n), 32'd4);
        itf.id_ready_i = 1'b0;
        repeat (3) step();

        // Address wrap through the top of the space.
        itf.redirect_i    = 1'b1;
        itf.redirect_pc_i = 32'hFFFF_FFF8;
        n_redir++;
        step();
        itf.redirect_i = 1'b0;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        itf.id_ready_i = 1'b1;
        drain(n);
        check("wrap_lat", 32'(n), 32'd6);
        itf.id_ready_i = 1'b0;
        repeat (3) step();

`ifdef FETCH_PERF_EN
        check("perf_fetch", fetch_cnt, 32'(n_pops));
        check("perf_flush", flush_cnt, 32'(n_redir));
`endif

        // Reset mid-stream overrides a simultaneous redirect.
        rst               = 1'b1;
        itf.redirect_i    = 1'b1;
        itf.redirect_pc_i = 32'h500;
        step();
        check("mrst_valid", {31'b0, itf.id_valid_o}, 32'd0);
        check("mrst_addr", itf.inst_addr_o, 32'h0);
        check("mrst_pc", itf.id_pc_o, 32'h0);
        check("mrst_inst", itf.id_inst_o, 32'h0);
`ifdef FETCH_PERF_EN
        check("mrst_fetch_cnt", fetch_cnt, 32'd0);
        check("mrst_flush_cnt", flush_cnt, 32'd0);
`endif
        rst            = 1'b0;
        itf.redirect_i = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        itf.id_ready_i = 1'b1;
        drain(n);
        check("mrst_lat", 32'(n), 32'd4);
        itf.id_ready_i = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
